// File: rtl/exmem_pkg.sv
// Shared types and helpers for the EX/MEM pipeline register.
package exmem_pkg;

   // Default field widths, matching the top-level parameter defaults.
   localparam int EXMEM_DATA_W = 32;
   localparam int EXMEM_RA_W   = 5;

   // WB/M control bits carried with every beat.
   typedef struct packed {
      logic regwr;
      logic m2r;
      logic memwr;
      logic memrd;
   } exmem_ctrl_t;

   // Full beat at default widths.
   typedef struct packed {
      exmem_ctrl_t              ctrl;
      logic [EXMEM_RA_W-1:0]    rd;
      logic [EXMEM_DATA_W-1:0]  aluout;
      logic [EXMEM_DATA_W-1:0]  stdata;
   } exmem_beat_t;

   // A killed beat keeps its data but must not write the register file or memory.
   function automatic exmem_ctrl_t kill_ctrl(input exmem_ctrl_t c);
      exmem_ctrl_t r;
      r       = c;
      r.regwr = 1'b0;
      r.memwr = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional 2-entry skid,
// per-beat kill and whole-stage flush.
module exmem_pipe_reg
   import exmem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RA_W    = 5,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwr,
   input  logic              in_m2r,
   input  logic              in_memwr,
   input  logic              in_memrd,
   input  logic [RA_W-1:0]   in_rd,
   input  logic [DATA_W-1:0] in_aluout,
   input  logic [DATA_W-1:0] in_stdata,
   input  logic              kill,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_regwr,
   output logic              out_m2r,
   output logic              out_memwr,
   output logic              out_memrd,
   output logic [RA_W-1:0]   out_rd,
   output logic [DATA_W-1:0] out_aluout,
   output logic [DATA_W-1:0] out_stdata,
   output logic [1:0]        occ
);

   // Beat layout at this instance's widths (package type covers the defaults).
   typedef struct packed {
      exmem_ctrl_t       ctrl;
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] aluout;
      logic [DATA_W-1:0] stdata;
   } beat_t;

   beat_t head_q, head_d;
   logic  head_v_q, head_v_d;
   beat_t skid_q;
   logic  skid_v_q;
   beat_t in_beat;
   logic  accept;
   logic  xfer;
   logic  head_free;

   assign accept    = in_valid & in_ready & ~flush;
   assign xfer      = head_v_q & out_ready;
   assign head_free = ~head_v_q | xfer;

   // Assemble the incoming beat, stripping side effects when killed.
   always_comb begin
      in_beat.ctrl.regwr = in_regwr;
      in_beat.ctrl.m2r   = in_m2r;
      in_beat.ctrl.memwr = in_memwr;
      in_beat.ctrl.memrd = in_memrd;
      in_beat.rd         = in_rd;
      in_beat.aluout     = in_aluout;
      in_beat.stdata     = in_stdata;
      if (kill) begin
         in_beat.ctrl = kill_ctrl(in_beat.ctrl);
      end
   end

   // Head next state: skid has priority over the incoming beat to keep FIFO order.
   always_comb begin
      head_d   = head_q;
      head_v_d = head_v_q;
      if (flush) begin
         head_v_d = 1'b0;
      end else if (head_free) begin
         if (skid_v_q) begin
            head_d   = skid_q;
            head_v_d = 1'b1;
         end else if (accept) begin
            head_d   = in_beat;
            head_v_d = 1'b1;
         end else begin
            head_v_d = 1'b0;
         end
      end
   end

   // Head register; data is held when the entry empties so payload outputs keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q   <= '0;
         head_v_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         head_v_q <= head_v_d;
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         beat_t skid_d;
         logic  skid_v_d;

         // Skid catches the one beat accepted while the head is stalled; it
         // always drains into the head as soon as the head frees up.
         always_comb begin
            skid_d   = skid_q;
            skid_v_d = skid_v_q;
            if (flush) begin
               skid_v_d = 1'b0;
            end else if (head_free) begin
               skid_v_d = 1'b0;
            end else if (accept) begin
               skid_d   = in_beat;
               skid_v_d = 1'b1;
            end
         end

         // Skid register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q   <= '0;
               skid_v_q <= 1'b0;
            end else begin
               skid_q   <= skid_d;
               skid_v_q <= skid_v_d;
            end
         end

         // Ready comes straight from a flop: no combinational path from out_ready.
         assign in_ready = ~skid_v_q;
      end else begin : g_noskid
         assign skid_q   = '0;
         assign skid_v_q = 1'b0;
         assign in_ready = ~head_v_q | out_ready;
      end
   endgenerate

   assign out_valid  = head_v_q;
   assign out_regwr  = head_q.ctrl.regwr & head_v_q;
   assign out_memwr  = head_q.ctrl.memwr & head_v_q;
   assign out_memrd  = head_q.ctrl.memrd & head_v_q;
   assign out_m2r    = head_q.ctrl.m2r;
   assign out_rd     = head_q.rd;
   assign out_aluout = head_q.aluout;
   assign out_stdata = head_q.stdata;
   assign occ        = {1'b0, head_v_q} + {1'b0, skid_v_q};

endmodule
